guia_0702_vector_sequencer: RTL and testbench

Upstream stimulus/check stage for the selectable AND/NAND unit (inputs a, b, select; output out).
- On a start request, walks every {a, b, select} combination in table order and holds each one for a programmable number of cycles.
- Samples the unit's result for each vector, compares it against the golden function and counts mismatches.
- Replaces hand-written #1 stimulus lists with a clocked, self-checking sequencer.

---
 rtl/guia_0702_vector_sequencer.sv | 128 ++++++++++++
 tb/tb_guia_0702_vector_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/guia_0702_vector_sequencer.sv
// Clocked stimulus/check sequencer for the selectable AND/NAND unit: walks every {a,b,select}
// vector, holds each for HOLD cycles, then checks dut_out. Optional capture: GUIA0702_FIRST_FAIL_EN.
module guia_0702_vector_sequencer #(
  parameter int WIDTH = 1,
  parameter int HOLD  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               select,
  input  logic [WIDTH-1:0]   dut_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   vec_idx,
  output logic [2*WIDTH+1:0] err_count,
  output logic [2*WIDTH:0]   first_fail_idx,
  output logic               first_fail_vld
);

  localparam int VW = 2*WIDTH + 1;
  localparam int EW = 2*WIDTH + 2;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
  localparam logic [VW-1:0] LAST_VEC = '1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]    state;
  logic [7:0]    hold_cnt;
  logic          mismatch;
  logic [EW-1:0] err_next;
  logic [VW-1:0] vec_next;

  function automatic logic [WIDTH-1:0] golden(input logic [VW-1:0] v);
    logic [WIDTH-1:0] ga;
    logic [WIDTH-1:0] gb;
    ga = v[VW-1:WIDTH+1];
    gb = v[WIDTH:1];
    return v[0] ? ~(ga & gb) : (ga & gb);
  endfunction

  function automatic logic [EW-1:0] sat_inc(input logic [EW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign mismatch = (state == SAMPLE) && (dut_out != golden(vec_idx));
  assign err_next = mismatch ? sat_inc(err_count) : err_count;
  assign vec_next = vec_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      vec_idx   <= '0;
      a         <= '0;
      b         <= '0;
      select    <= 1'b0;
      err_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state          <= DRIVE;
            vec_idx        <= '0;
            {a, b, select} <= '0;
            err_count      <= '0;
            pass           <= 1'b0;
            hold_cnt       <= '0;
            busy           <= 1'b1;
          end
        end
        DRIVE: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            state    <= SAMPLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          err_count <= err_next;
          // pass uses err_next so the final vector's mismatch is included
          if (vec_idx == LAST_VEC) begin
            state <= FINISH;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            vec_idx        <= vec_next;
            {a, b, select} <= vec_next;
            state          <= DRIVE;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef GUIA0702_FIRST_FAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else if (state == IDLE && start) begin
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else if (mismatch && !first_fail_vld) begin
      first_fail_idx <= vec_idx;
      first_fail_vld <= 1'b1;
    end
  end
`else
  assign first_fail_idx = '0;
  assign first_fail_vld = 1'b0;
`endif

endmodule

// File: tb/tb_guia_0702_vector_sequencer.sv
// Scoreboard bench for guia_0702_vector_sequencer: three instances (W1/H1, W1/H3, W2/H1)
// fed by a behavioural AND/NAND unit that can be correct, stuck at 0 or inverted.
module tb_guia_0702_vector_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mode = 0;
  int cur = 0;

  // instance 0: WIDTH=1 HOLD=1
  logic start0 = 1'b0;
  logic [0:0] a0, b0, d0;
  logic s0, busy0, done0, pass0, ffv0;
  logic [2:0] vec0, ffi0;
  logic [3:0] err0;
  // instance 1: WIDTH=1 HOLD=3
  logic start1 = 1'b0;
  logic [0:0] a1, b1, d1;
  logic s1, busy1, done1, pass1, ffv1;
  logic [2:0] vec1, ffi1;
  logic [3:0] err1;
  // instance 2: WIDTH=2 HOLD=1
  logic start2 = 1'b0;
  logic [1:0] a2, b2, d2;
  logic s2, busy2, done2, pass2, ffv2;
  logic [4:0] vec2, ffi2;
  logic [5:0] err2;

  guia_0702_vector_sequencer #(.WIDTH(1), .HOLD(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .select(s0), .dut_out(d0),
    .busy(busy0), .done(done0), .pass(pass0), .vec_idx(vec0), .err_count(err0),
    .first_fail_idx(ffi0), .first_fail_vld(ffv0));
  guia_0702_vector_sequencer #(.WIDTH(1), .HOLD(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .select(s1), .dut_out(d1),
    .busy(busy1), .done(done1), .pass(pass1), .vec_idx(vec1), .err_count(err1),
    .first_fail_idx(ffi1), .first_fail_vld(ffv1));
  guia_0702_vector_sequencer #(.WIDTH(2), .HOLD(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .select(s2), .dut_out(d2),
    .busy(busy2), .done(done2), .pass(pass2), .vec_idx(vec2), .err_count(err2),
    .first_fail_idx(ffi2), .first_fail_vld(ffv2));

  function automatic logic [1:0] unit(input logic [1:0] ua, input logic [1:0] ub,
                                      input logic us, input int m);
    logic [1:0] r;
    r = us ? ~(ua & ub) : (ua & ub);
    if (m == 1) r = 2'b00;
    else if (m == 2) r = ~r;
    return r;
  endfunction

  assign d0 = unit({1'b0, a0}, {1'b0, b0}, s0, mode) & 2'b01;
  assign d1 = unit({1'b0, a1}, {1'b0, b1}, s1, mode) & 2'b01;
  assign d2 = unit(a2, b2, s2, mode);

  logic [4:0] ob_vec, ob_ops, ob_ffi;
  logic [5:0] ob_err;
  logic ob_busy, ob_done, ob_pass, ob_ffv;

  always_comb begin
    ob_vec = {2'b00, vec0}; ob_ops = {2'b00, a0, b0, s0}; ob_ffi = {2'b00, ffi0};
    ob_err = {2'b00, err0}; ob_busy = busy0; ob_done = done0; ob_pass = pass0; ob_ffv = ffv0;
    if (cur == 1) begin
      ob_vec = {2'b00, vec1}; ob_ops = {2'b00, a1, b1, s1}; ob_ffi = {2'b00, ffi1};
      ob_err = {2'b00, err1}; ob_busy = busy1; ob_done = done1; ob_pass = pass1; ob_ffv = ffv1;
    end else if (cur == 2) begin
      ob_vec = vec2; ob_ops = {a2, b2, s2}; ob_ffi = ffi2;
      ob_err = err2; ob_busy = busy2; ob_done = done2; ob_pass = pass2; ob_ffv = ffv2;
    end
  end

  task automatic set_start(input logic v);
    start0 = (cur == 0) ? v : 1'b0;
    start1 = (cur == 1) ? v : 1'b0;
    start2 = (cur == 2) ? v : 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cur = i;
      #1;
      checks++;
      if (ob_vec !== 5'd0 || ob_ops !== 5'd0 || ob_err !== 6'd0 || ob_busy !== 1'b0 ||
          ob_done !== 1'b0 || ob_pass !== 1'b0 || ob_ffi !== 5'd0 || ob_ffv !== 1'b0)
        $display("FAIL reset_state inst%0d: vec=%0d ops=%0d err=%0d busy=%b done=%b pass=%b ffi=%0d ffv=%b required all 0",
                 i, ob_vec, ob_ops, ob_err, ob_busy, ob_done, ob_pass, ob_ffi, ob_ffv);
      if (ob_vec !== 5'd0 || ob_ops !== 5'd0 || ob_err !== 6'd0 || ob_busy !== 1'b0 ||
          ob_done !== 1'b0 || ob_pass !== 1'b0 || ob_ffi !== 5'd0 || ob_ffv !== 1'b0)
        errors++;
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  // One run; restart_at / abort_at are cycle offsets from the start edge (-1 disables).
  task automatic run_seq(input int inst, input int m, input int restart_at, input int abort_at,
                         input string name);
    int w, h, n, total, exp_err, ff, ev;
    int vq[$];
    logic [1:0] ea, eb, ex, act, mask;
    logic es;
    logic exp_ffv;
    logic [4:0] exp_ffi;
    cur = inst;
    mode = m;
    w = (inst == 2) ? 2 : 1;
    h = (inst == 1) ? 3 : 1;
    n = 1 << (2*w + 1);
    total = n * (h + 1);
    mask = (w == 2) ? 2'b11 : 2'b01;
    exp_err = 0;
    ff = -1;
    for (int v = 0; v < n; v++) begin
      ea = 2'((v >> (w + 1))) & mask;
      eb = 2'((v >> 1)) & mask;
      es = v[0];
      ex = (es ? ~(ea & eb) : (ea & eb)) & mask;
      act = (m == 0) ? ex : (m == 1) ? 2'b00 : (~ex & mask);
      if (act != ex) begin
        exp_err++;
        if (ff < 0) ff = v;
      end
    end
`ifdef GUIA0702_FIRST_FAIL_EN
    exp_ffv = (ff >= 0);
    exp_ffi = (ff >= 0) ? 5'(ff) : 5'd0;
`else
    exp_ffv = 1'b0;
    exp_ffi = 5'd0;
`endif
    for (int c = 0; c < total; c++) vq.push_back(c / (h + 1));

    @(negedge clk) set_start(1'b1);
    @(posedge clk);
    #1 set_start(1'b0);
    for (int c = 0; c < total; c++) begin
      ev = vq.pop_front();
      checks++;
      if (ob_vec !== 5'(ev) || ob_ops !== 5'(ev) || ob_busy !== 1'b1 || ob_done !== 1'b0) begin
        errors++;
        $display("FAIL %s_step cyc=%0d: vec=%0d ops=%0d busy=%b done=%b required vec=ops=%0d busy=1 done=0",
                 name, c, ob_vec, ob_ops, ob_busy, ob_done, ev);
      end
      if (c == restart_at) set_start(1'b1);
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (ob_vec !== 5'd0 || ob_ops !== 5'd0 || ob_err !== 6'd0 || ob_busy !== 1'b0 ||
            ob_done !== 1'b0 || ob_pass !== 1'b0 || ob_ffv !== 1'b0) begin
          errors++;
          $display("FAIL %s_abort: vec=%0d ops=%0d err=%0d busy=%b done=%b pass=%b ffv=%b required all 0",
                   name, ob_vec, ob_ops, ob_err, ob_busy, ob_done, ob_pass, ob_ffv);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ob_done !== 1'b0 || ob_busy !== 1'b0) begin
          errors++;
          $display("FAIL %s_post_abort: done=%b busy=%b required 0 0", name, ob_done, ob_busy);
        end
        return;
      end
      @(posedge clk);
      #1 set_start(1'b0);
    end
    checks++;
    if (ob_done !== 1'b1 || ob_err !== 6'(exp_err) || ob_pass !== (exp_err == 0) ||
        ob_ffv !== exp_ffv || ob_ffi !== exp_ffi) begin
      errors++;
      $display("FAIL %s_done: done=%b err=%0d pass=%b ffv=%b ffi=%0d required done=1 err=%0d pass=%b ffv=%b ffi=%0d",
               name, ob_done, ob_err, ob_pass, ob_ffv, ob_ffi, 1'b1, exp_err, (exp_err == 0), exp_ffv, exp_ffi);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ob_done !== 1'b0 || ob_busy !== 1'b0 || ob_vec !== 5'(n - 1) || ob_ops !== 5'(n - 1) ||
        ob_err !== 6'(exp_err) || ob_pass !== (exp_err == 0)) begin
      errors++;
      $display("FAIL %s_idle: done=%b busy=%b vec=%0d ops=%0d err=%0d pass=%b required 0 0 %0d %0d %0d %b",
               name, ob_done, ob_busy, ob_vec, ob_ops, ob_err, ob_pass, n - 1, n - 1, exp_err, (exp_err == 0));
    end
  endtask

  task automatic test_clean_run;        run_seq(0, 0, -1, -1, "clean");     endtask
  task automatic test_stuck_zero;       run_seq(0, 1, -1, -1, "stuck0");    endtask
  task automatic test_inverted;         run_seq(0, 2, -1, -1, "inverted");  endtask
  task automatic test_hold3;            run_seq(1, 0, -1, -1, "hold3");     endtask
  task automatic test_restart_ignored;  run_seq(0, 1, 6, -1, "restart");    endtask
  task automatic test_width2;           run_seq(2, 0, -1, -1, "width2");    endtask
  task automatic test_width2_inverted;  run_seq(2, 2, -1, -1, "width2_inv"); endtask

  task automatic test_reset_mid_run;
    run_seq(0, 1, -1, 11, "midreset");
    run_seq(0, 0, -1, -1, "after_reset");
  endtask

  task automatic test_back_to_back;
    run_seq(0, 2, -1, -1, "b2b_first");
    run_seq(0, 0, -1, -1, "b2b_second");
  endtask

  initial begin
    test_reset;
    test_clean_run;
    test_stuck_zero;
    test_inverted;
    test_hold3;
    test_restart_ignored;
    test_reset_mid_run;
    test_back_to_back;
    test_width2;
    test_width2_inverted;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
